// File: rtl/vga_sync_decoder_if.sv
// Pin-side VGA stream plus the recovered timing/checksum outputs of the decoder.
interface vga_sync_decoder_if;
    logic        hsync;
    logic        vsync;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        locked;
    logic        pix_valid;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] rgb_out;
    logic        frame_start;
    logic        h_err;
    logic        v_err;
    logic [15:0] frame_sum;
    logic        frame_sum_valid;
    logic [7:0]  frame_count;

    // Source side: drives the pins, observes the decoder results.
    modport master (
        output hsync, vsync, r, g, b,
        input  locked, pix_valid, x, y, rgb_out, frame_start,
               h_err, v_err, frame_sum, frame_sum_valid, frame_count
    );

    // Decoder side.
    modport slave (
        input  hsync, vsync, r, g, b,
        output locked, pix_valid, x, y, rgb_out, frame_start,
               h_err, v_err, frame_sum, frame_sum_valid, frame_count
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// VGA receive-side timing recovery: locks to the sync stream, recovers x/y and
// the active-pixel qualifier, flags line/frame length errors and sums each
// complete locked frame.
//
// state  | meaning
// SEARCH | waiting for one correct-length line
// ACQ_H  | line timing seen, waiting for the first frame edge
// ACQ_V  | measuring a full frame between frame edges
// LOCKED | timing confirmed; pixels qualified, errors and checksums reported
module vga_sync_decoder #(
    parameter int H_TOTAL  = 800,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int V_TOTAL  = 525,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter bit SYNC_POL = 1'b0
) (
    input logic               clk,
    input logic               reset,
    vga_sync_decoder_if.slave vga
);

    localparam bit          SYNC_OFF  = !SYNC_POL;
    localparam logic [11:0] LINE_LEN  = 12'(H_TOTAL);
    localparam logic [10:0] FRAME_LEN = 11'(V_TOTAL);
    localparam logic [10:0] H_FIRST   = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_LAST    = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0]  V_FIRST   = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_LAST    = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [10:0] H_MAX     = 11'd2047;
    localparam logic [9:0]  V_MAX     = 10'd1023;

    typedef enum logic [1:0] {SEARCH, ACQ_H, ACQ_V, LOCKED} state_t;

    state_t      state;
    logic        hs1, vs1, hs_prev, vs_hist;
    logic [11:0] rgb1;
    // hcnt/vcnt hold the position of the previous stage-1 sample, so the
    // length of a completed line/frame is simply count+1 at the next edge.
    logic [10:0] hcnt;
    logic [9:0]  vcnt;
    logic [15:0] run_sum;

    logic        hs_edge, frame_edge, line_bad, frame_bad, frame_good, h_lost;
    logic        active;
    logic [11:0] line_len;
    logic [10:0] frame_len;
    logic [10:0] hc_cur;
    logic [9:0]  vc_cur;
    logic [15:0] sum_next;

    // Edge detection and the position of the pixel currently in stage 1.
    always_comb begin
        hs_edge    = (hs1 == SYNC_POL) && (hs_prev != SYNC_POL);
        frame_edge = hs_edge && (vs1 == SYNC_POL) && (vs_hist != SYNC_POL);
        line_len   = {1'b0, hcnt} + 12'd1;
        frame_len  = {1'b0, vcnt} + 11'd1;
        line_bad   = hs_edge && (line_len != LINE_LEN);
        frame_bad  = frame_edge && (frame_len != FRAME_LEN);
        frame_good = frame_edge && (frame_len == FRAME_LEN);
        h_lost     = !hs_edge && (hcnt == H_MAX - 11'd1);
        if (hs_edge)
            hc_cur = '0;
        else if (hcnt == H_MAX)
            hc_cur = H_MAX;
        else
            hc_cur = hcnt + 11'd1;
        vc_cur = vcnt;
        if (frame_edge)
            vc_cur = '0;
        else if (hs_edge && (vcnt != V_MAX))
            vc_cur = vcnt + 10'd1;
        active   = (hc_cur >= H_FIRST) && (hc_cur <= H_LAST) &&
                   (vc_cur >= V_FIRST) && (vc_cur <= V_LAST);
        sum_next = run_sum + ((active && (state == LOCKED)) ? {4'd0, rgb1} : 16'd0);
    end

    // Input stage, counters, lock FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= SEARCH;
            hs1                 <= SYNC_OFF;
            vs1                 <= SYNC_OFF;
            hs_prev             <= SYNC_OFF;
            vs_hist             <= SYNC_OFF;
            rgb1                <= '0;
            hcnt                <= '0;
            vcnt                <= '0;
            run_sum             <= '0;
            vga.locked          <= 1'b0;
            vga.pix_valid       <= 1'b0;
            vga.x               <= '0;
            vga.y               <= '0;
            vga.rgb_out         <= '0;
            vga.frame_start     <= 1'b0;
            vga.h_err           <= 1'b0;
            vga.v_err           <= 1'b0;
            vga.frame_sum       <= '0;
            vga.frame_sum_valid <= 1'b0;
            vga.frame_count     <= '0;
        end else begin
            hs1     <= vga.hsync;
            vs1     <= vga.vsync;
            rgb1    <= {vga.r, vga.g, vga.b};
            hs_prev <= hs1;
            if (hs_edge)
                vs_hist <= vs1;
            hcnt    <= hc_cur;
            vcnt    <= vc_cur;
            run_sum <= sum_next;

            vga.pix_valid       <= active && (state == LOCKED);
            vga.rgb_out         <= rgb1;
            vga.frame_start     <= frame_edge;
            vga.h_err           <= 1'b0;
            vga.v_err           <= 1'b0;
            vga.frame_sum_valid <= 1'b0;
            if (active) begin
                vga.x <= 10'(hc_cur - H_FIRST);
                vga.y <= vc_cur - V_FIRST;
            end

            case (state)
                SEARCH: begin
                    if (hs_edge && (line_len == LINE_LEN))
                        state <= ACQ_H;
                end
                ACQ_H: begin
                    if (line_bad)
                        state <= SEARCH;
                    else if (frame_edge)
                        state <= ACQ_V;
                end
                ACQ_V: begin
                    if (line_bad) begin
                        state <= SEARCH;
                    end else if (frame_good) begin
                        state      <= LOCKED;
                        vga.locked <= 1'b1;
                        run_sum    <= '0;
                    end
                end
                LOCKED: begin
                    if (line_bad || frame_bad || h_lost) begin
                        vga.h_err  <= line_bad || h_lost;
                        vga.v_err  <= frame_bad;
                        state      <= SEARCH;
                        vga.locked <= 1'b0;
                        run_sum    <= '0;
                    end else if (frame_good) begin
                        vga.frame_sum       <= sum_next;
                        vga.frame_sum_valid <= 1'b1;
                        vga.frame_count     <= vga.frame_count + 8'd1;
                        run_sum             <= '0;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a shrunken raster (40x20 clocks,
// 24x12 active). The driver pushes expected pixels, frame starts and frame
// sums into queues; a negedge monitor pops and compares as the DUT emits them.
module tb_vga_sync_decoder;
    localparam int HT = 40, HS = 4, HB = 4, HA = 24;
    localparam int VT = 20, VS = 2, VB = 3, VA = 12;
    localparam bit POL = 1'b0;
    localparam int HST = HS + HB;
    localparam int VST = VS + VB;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    vga_sync_decoder_if vif ();

    vga_sync_decoder #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA),
        .SYNC_POL(POL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .vga  (vif)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] c;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] rgb;
    } pix_t;
    typedef struct packed {
        logic [15:0] s;
        logic [7:0]  n;
    } sum_t;

    pix_t        pix_q[$];
    sum_t        sum_q[$];
    int          fs_q[$];
    pix_t        pe, pa;
    sum_t        se;
    int          fe;
    int          n_herr = 0;
    int          n_verr = 0;
    logic [15:0] acc;
    logic [7:0]  exp_count = 8'd0;

    // Monitor: every output event is matched against the head of its queue.
    always @(negedge clk) begin
        if (vif.pix_valid) begin
            checks++;
            pa = {32'(cyc), vif.x, vif.y, vif.rgb_out};
            if (pix_q.size() == 0) begin
                errors++;
                $display("FAIL pix_unexpected: got x=%0d y=%0d rgb=%h at cyc %0d, required none",
                         vif.x, vif.y, vif.rgb_out, cyc);
            end else begin
                pe = pix_q.pop_front();
                if (pa !== pe) begin
                    errors++;
                    $display("FAIL pix: got cyc=%0d x=%0d y=%0d rgb=%h, required cyc=%0d x=%0d y=%0d rgb=%h",
                             pa.c, pa.x, pa.y, pa.rgb, pe.c, pe.x, pe.y, pe.rgb);
                end
            end
        end
        if (vif.frame_sum_valid) begin
            checks++;
            if (sum_q.size() == 0) begin
                errors++;
                $display("FAIL sum_unexpected: got sum=%0d count=%0d, required none",
                         vif.frame_sum, vif.frame_count);
            end else begin
                se = sum_q.pop_front();
                if (vif.frame_sum !== se.s || vif.frame_count !== se.n) begin
                    errors++;
                    $display("FAIL frame_sum: got sum=%0d count=%0d, required sum=%0d count=%0d",
                             vif.frame_sum, vif.frame_count, se.s, se.n);
                end
            end
        end
        if (vif.frame_start) begin
            checks++;
            if (fs_q.size() == 0) begin
                errors++;
                $display("FAIL fs_unexpected: got pulse at cyc %0d, required none", cyc);
            end else begin
                fe = fs_q.pop_front();
                if (cyc != fe) begin
                    errors++;
                    $display("FAIL frame_start: got cyc %0d, required cyc %0d", cyc, fe);
                end
            end
        end
        if (vif.h_err) n_herr++;
        if (vif.v_err) n_verr++;
    end

    always @(posedge clk) begin
        if (cyc > 60000) begin
            $display("FAIL watchdog: got cyc %0d, required < 60000", cyc);
            $fatal(1, "watchdog");
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_locked"}, 32'(vif.locked), 0);
        chk({tag, "_pix_valid"}, 32'(vif.pix_valid), 0);
        chk({tag, "_x"}, 32'(vif.x), 0);
        chk({tag, "_y"}, 32'(vif.y), 0);
        chk({tag, "_rgb_out"}, 32'(vif.rgb_out), 0);
        chk({tag, "_frame_start"}, 32'(vif.frame_start), 0);
        chk({tag, "_h_err"}, 32'(vif.h_err), 0);
        chk({tag, "_v_err"}, 32'(vif.v_err), 0);
        chk({tag, "_frame_sum"}, 32'(vif.frame_sum), 0);
        chk({tag, "_frame_sum_valid"}, 32'(vif.frame_sum_valid), 0);
        chk({tag, "_frame_count"}, 32'(vif.frame_count), 0);
    endtask

    // One line; mode 0 = constant 12'h00F, mode 1 = position-dependent colour.
    task automatic drive_line(input int row, input int len, input bit lk, input int mode);
        logic [11:0] px;
        for (int c = 0; c < len; c++) begin
            px = (mode == 0) ? 12'h00F : {4'(c), 4'(row), 4'(c + row)};
            vif.hsync = (c < HS) ? POL : !POL;
            vif.vsync = (row < VS) ? POL : !POL;
            {vif.r, vif.g, vif.b} = px;
            if (c == 0 && row == 0)
                fs_q.push_back(cyc + 2);
            if (lk && c >= HST && c < HST + HA && row >= VST && row < VST + VA) begin
                pix_q.push_back({32'(cyc + 2), 10'(c - HST), 10'(row - VST), px});
                acc += {4'd0, px};
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Lines first..nlines-1; lines up to lk_last are expected locked.
    task automatic drive_frame(input int first, input int nlines, input int lk_last,
                               input int mode, input int bad_line);
        if (first == 0) acc = '0;
        for (int r = first; r < nlines; r++)
            drive_line(r, (r == bad_line) ? HT + 1 : HT, r <= lk_last, mode);
    endtask

    task automatic push_sum();
        exp_count++;
        sum_q.push_back({acc, exp_count});
    endtask

    initial begin
        vif.hsync = !POL;
        vif.vsync = !POL;
        {vif.r, vif.g, vif.b} = 12'h000;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Acquire: bad first line, good line, frame A -> ACQ_V, frame B -> LOCKED.
        drive_line(99, HT, 1'b0, 0);
        drive_line(99, HT, 1'b0, 0);
        drive_frame(0, VT, -1, 0, -1);
        @(negedge clk);
        chk("locked_before_2nd_edge", 32'(vif.locked), 0);
        drive_frame(0, VT, VT - 1, 0, -1);
        exp_count = 8'd1;
        sum_q.push_back({16'd4320, 8'd1});
        chk("locked_after_2nd_edge", 32'(vif.locked), 1);
        drive_frame(0, VT, VT - 1, 1, -1);
        push_sum();

        // One 41-clock line while locked.
        drive_frame(0, VT, 8, 1, 8);
        @(negedge clk);
        chk("h_err_count_long_line", 32'(n_herr), 1);
        chk("locked_after_long_line", 32'(vif.locked), 0);
        chk("v_err_count_long_line", 32'(n_verr), 0);
        drive_frame(0, VT, -1, 1, -1);
        @(negedge clk);
        chk("locked_one_edge_after_h_err", 32'(vif.locked), 0);
        drive_frame(0, VT, VT - 1, 1, -1);
        push_sum();
        chk("relocked_after_h_err", 32'(vif.locked), 1);

        // Short frame while locked.
        drive_frame(0, VT - 1, VT - 2, 1, -1);
        drive_frame(0, VT, -1, 1, -1);
        @(negedge clk);
        chk("v_err_count_short_frame", 32'(n_verr), 1);
        chk("h_err_count_short_frame", 32'(n_herr), 1);
        chk("locked_after_short_frame", 32'(vif.locked), 0);
        drive_frame(0, VT, -1, 1, -1);
        drive_frame(0, VT, VT - 1, 1, -1);
        push_sum();

        // hsync lost while locked.
        drive_frame(0, 9, 8, 1, -1);
        vif.hsync = !POL;
        vif.vsync = !POL;
        repeat (3000) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("h_err_count_hsync_lost", 32'(n_herr), 2);
        chk("locked_after_hsync_lost", 32'(vif.locked), 0);

        // Re-lock, then reset in the middle of a locked frame.
        drive_line(99, HT, 1'b0, 1);
        drive_line(99, HT, 1'b0, 1);
        drive_frame(0, VT, -1, 1, -1);
        drive_frame(0, 3, 2, 1, -1);
        @(negedge clk);
        chk("locked_before_mid_reset", 32'(vif.locked), 1);
        chk("frame_count_before_mid_reset", 32'(vif.frame_count), 32'(exp_count));
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_zero("mid_reset");
        reset = 1'b0;
        exp_count = 8'd0;
        drive_frame(3, VT, -1, 1, -1);
        drive_frame(0, VT, -1, 1, -1);
        @(negedge clk);
        chk("locked_one_edge_after_reset", 32'(vif.locked), 0);
        drive_frame(0, VT, VT - 1, 1, -1);
        push_sum();
        drive_frame(0, 3, 2, 1, -1);

        repeat (4) @(negedge clk);
        chk("pix_queue_drained", 32'(pix_q.size()), 0);
        chk("sum_queue_drained", 32'(sum_q.size()), 0);
        chk("fs_queue_drained", 32'(fs_q.size()), 0);
        chk("frame_count_final", 32'(vif.frame_count), 1);
        chk("h_err_count_final", 32'(n_herr), 2);
        chk("v_err_count_final", 32'(n_verr), 1);
        chk("locked_final", 32'(vif.locked), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the VGA timing generator. Samples the hsync, vsync and 12-bit RGB pin stream on the 25 MHz pixel clock.
- Locks to the 640x480@60 timing, recovers the pixel coordinates and the active-pixel qualifier, and flags timing errors.
- Produces a per-frame RGB checksum. Used for on-board self-test and for bench loop-back checking of the game display path.

Parameters:
H_TOTAL, 800, clocks per line
H_SYNC, 96, hsync pulse width, clocks
H_BP, 48, back porch, clocks
H_ACTIVE, 640, active pixels per line
V_TOTAL, 525, lines per frame
V_SYNC, 2, vsync width, lines
V_BP, 33, back porch, lines
V_ACTIVE, 480, active lines
SYNC_POL, 0, sync asserted level (0 = active-low)

Ports:
clk  in  1  pixel clock (25 MHz). The block's only clock.
reset  in  1  synchronous, active-high reset
hsync  in  1  horizontal sync from the VGA pins
vsync  in  1  vertical sync from the VGA pins
r, g, b  in  4 each  pixel colour
locked  out  1  timing lock achieved
pix_valid  out  1  current output pixel is active and locked
x  out  10  recovered column, 0..639
y  out  10  recovered row, 0..479
rgb_out  out  12  {r,g,b} aligned with pix_valid
frame_start  out  1  1-clock pulse at each detected frame start
h_err  out  1  1-clock pulse on a bad line length
v_err  out  1  1-clock pulse on a bad frame length
frame_sum  out  16  checksum of the last complete locked frame
frame_sum_valid  out  1  1-clock pulse when frame_sum updates
frame_count  out  8  locked frames completed, wraps 255->0

Behaviour:
- Reset:
  - All outputs 0; state SEARCH.
  - hcnt = 0; vcnt = 0; running checksum = 0.
  - Sync history registers are loaded with the deasserted level.
- Input stage:
  - hsync, vsync and rgb are registered once (stage 1).
  - All outputs are registered, giving a fixed 2-clock latency from pin sample to x/y/pix_valid/rgb_out.
- Horizontal counting:
  - hs_edge = stage-1 hsync at SYNC_POL while the previous sample was not.
  - On hs_edge: line_len = hcnt+1, then hcnt <= 0.
  - Otherwise hcnt increments, saturating at 2047 (11 bits).
- Vertical counting:
  - Vertical events are evaluated only on hs_edge. vsync is sampled at each hs_edge.
  - frame_edge = vsync asserted at this hs_edge and not asserted at the previous hs_edge.
  - On frame_edge: frame_len = vcnt+1, then vcnt <= 0.
  - On any other hs_edge: vcnt increments, saturating at 1023.
  - When the mid-line vsync phase varies, the result is a whole-line quantisation.
- Active region:
  - Columns: hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1]; x = hcnt-144.
  - Rows: vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1]; y = vcnt-35.
  - pix_valid = inside both ranges AND state LOCKED.
  - Outside the active region, x and y hold their last values.
- State machine:
  - SEARCH: on hs_edge with line_len == H_TOTAL -> ACQ_H.
  - ACQ_H:
    - hs_edge with line_len != H_TOTAL -> SEARCH.
    - frame_edge -> ACQ_V.
  - ACQ_V:
    - hs_edge with line_len != H_TOTAL -> SEARCH.
    - frame_edge with frame_len == V_TOTAL -> LOCKED.
    - frame_edge with any other frame_len -> ACQ_V; restart the count.
  - LOCKED:
    - hs_edge with line_len != H_TOTAL: h_err pulse, -> SEARCH.
    - frame_edge with frame_len != V_TOTAL: v_err pulse, -> SEARCH.
    - hcnt reaching 2047 (hsync lost): h_err pulse, -> SEARCH.
  - locked = (state == LOCKED).
  - h_err and v_err are generated only in LOCKED.
  - If both errors occur in the same cycle, both pulse and the next state is SEARCH.
- frame_start: pulses on every frame_edge in any state, aligned to the output latency.
- Checksum:
  - Running 16-bit modular sum of the zero-extended {r,g,b} on every pix_valid cycle.
  - On frame_edge while LOCKED with frame_len == V_TOTAL:
    - frame_sum <= running sum (including the last pixel);
    - frame_sum_valid pulses;
    - frame_count increments;
    - running sum clears.
  - The running sum also clears on leaving LOCKED and on the ACQ_V->LOCKED transition.
  - A partial frame never updates frame_sum.
- Reset mid-frame: immediate return to the reset state; re-lock requires the full SEARCH->ACQ_H->ACQ_V->LOCKED sequence (at least one complete frame plus one line).

Test Plan:
- Nominal 800x525 timing, constant rgb=12'h00F, reset released at a line boundary:
  - locked rises at the 2nd frame_edge after reset.
  - Next frame: 307200 pix_valid cycles; x sweeps 0..639, y sweeps 0..479.
  - frame_sum = (307200*15) mod 65536 = 20480; frame_count = 1.
- Latency check: first active pixel of row 0 driven on the pins -> pix_valid=1, x=0, y=0 exactly 2 clocks later.
- Single 801-clock line injected while LOCKED:
  - h_err pulses once; locked drops.
  - Re-lock occurs after 2 further good frame_edges.
  - No frame_sum_valid is produced for the broken frame.
- 524-line frame while LOCKED: v_err pulses at that frame_edge; state goes to SEARCH.
- hsync held deasserted for 3000 clocks while LOCKED: h_err pulses when hcnt reaches 2047; locked = 0.
- reset asserted mid-frame in LOCKED:
  - Next clock: all outputs 0.
  - frame_count = 0.
  - pix_valid stays 0 until re-locked.
